// File: rtl/match_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : match_event_logger
// Purpose  : Timestamps detector match pulses into a small FWFT FIFO and
//            presents them over valid/ready, with saturating statistics.
// Revision : 1.0 - initial release
// ============================================================================
module match_event_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     match_in,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TS_W-1:0]          evt_time,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         total_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0]    c_FULL    = LW'(DEPTH);
    localparam logic [LW-1:0]    c_LVL_ONE = LW'(1);
    localparam logic [AW-1:0]    c_PTR_ONE = AW'(1);
    localparam logic [TS_W-1:0]  c_TS_ONE  = TS_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [TS_W-1:0]  r_ts;
    logic [TS_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic [TS_W-1:0]  r_evt_time;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_drop;
    logic             r_ovf;

    logic             w_empty;
    logic             w_full;
    logic             w_hit;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [LW-1:0]    w_level_nxt;
    logic [AW-1:0]    w_rptr_nxt;
    logic [TS_W-1:0]  w_head_nxt;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_FULL);
    assign w_hit   = ~clear & match_in;
    assign w_pop   = ~clear & ~w_empty & evt_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_push  = w_hit & (~w_full | w_pop);
    assign w_drop  = w_hit & w_full & ~w_pop;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_LVL_ONE;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - c_LVL_ONE;
        end

        w_rptr_nxt = w_pop ? (r_rptr + c_PTR_ONE) : r_rptr;

        // Registered head: the new record becomes head only when nothing
        // older survives this edge; an empty FIFO keeps the last head value.
        w_head_nxt = r_evt_time;
        if (w_push && (r_level == (w_pop ? c_LVL_ONE : '0))) begin
            w_head_nxt = r_ts;
        end else if (w_level_nxt != '0) begin
            w_head_nxt = r_mem[w_rptr_nxt];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= r_ts;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ts       <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_evt_time <= '0;
            r_total    <= '0;
            r_drop     <= '0;
            r_ovf      <= 1'b0;
        end else if (clear) begin
            r_ts       <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_evt_time <= '0;
            r_total    <= '0;
            r_drop     <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_ts       <= r_ts + c_TS_ONE;
            r_rptr     <= w_rptr_nxt;
            r_level    <= w_level_nxt;
            r_evt_time <= w_head_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_hit && (r_total != c_CNT_MAX)) begin
                r_total <= r_total + c_CNT_ONE;
            end
            if (w_drop) begin
                r_ovf <= 1'b1;
                if (r_drop != c_CNT_MAX) begin
                    r_drop <= r_drop + c_CNT_ONE;
                end
            end
        end
    end

    assign evt_valid  = ~w_empty;
    assign evt_time   = r_evt_time;
    assign fifo_level = r_level;
    assign total_cnt  = r_total;
    assign drop_cnt   = r_drop;
    assign overflow   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_match_event_logger.sv
`default_nettype none
// ============================================================================
// Module   : tb_match_event_logger
// Purpose  : Directed and random checks of two logger configurations against
//            an ordered-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_match_event_logger;

    logic clk = 1'b0;
    logic rst;
    logic clr;
    logic match;
    logic ready;

    logic        v0, o0, v1, o1;
    logic [15:0] t0;
    logic [3:0]  t1;
    logic [2:0]  l0, l1;
    logic [7:0]  tc0, dc0;
    logic [1:0]  tc1, dc1;

    int n_total = 0;
    int n_bad   = 0;

    // Index 0: default configuration; index 1: TS_W=4, CNT_W=2.
    int m_ts[2], m_n[2], m_tot[2], m_drop[2], m_ovf[2], m_last[2];
    int m_f[2][4];

    always #5 clk = ~clk;

    match_event_logger dut (
        .clk(clk), .rst(rst), .clear(clr), .match_in(match),
        .evt_valid(v0), .evt_ready(ready), .evt_time(t0), .fifo_level(l0),
        .total_cnt(tc0), .drop_cnt(dc0), .overflow(o0)
    );

    match_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .clear(clr), .match_in(match),
        .evt_valid(v1), .evt_ready(ready), .evt_time(t1), .fifo_level(l1),
        .total_cnt(tc1), .drop_cnt(dc1), .overflow(o1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ts_max(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic int cnt_max(input int k);
        return (k == 0) ? 255 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ts[k] = 0; m_n[k] = 0; m_tot[k] = 0;
            m_drop[k] = 0; m_ovf[k] = 0; m_last[k] = 0;
        end
    endtask

    task automatic model_step();
        int val;
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_ts[k] = 0; m_n[k] = 0; m_tot[k] = 0;
                m_drop[k] = 0; m_ovf[k] = 0; m_last[k] = 0;
            end else begin
                val = m_ts[k];
                if (m_n[k] > 0 && ready) begin
                    for (int i = 0; i < 3; i++) m_f[k][i] = m_f[k][i+1];
                    m_n[k]--;
                end
                if (match) begin
                    if (m_tot[k] < cnt_max(k)) m_tot[k]++;
                    if (m_n[k] < 4) begin
                        m_f[k][m_n[k]] = val;
                        m_n[k]++;
                    end else begin
                        if (m_drop[k] < cnt_max(k)) m_drop[k]++;
                        m_ovf[k] = 1;
                    end
                end
                m_ts[k] = (m_ts[k] == ts_max(k)) ? 0 : m_ts[k] + 1;
                if (m_n[k] > 0) m_last[k] = m_f[k][0];
            end
        end
    endtask

    task automatic check_all();
        chk("valid0", int'(v0),  int'(m_n[0] > 0));
        chk("time0",  int'(t0),  m_last[0]);
        chk("level0", int'(l0),  m_n[0]);
        chk("total0", int'(tc0), m_tot[0]);
        chk("drop0",  int'(dc0), m_drop[0]);
        chk("ovf0",   int'(o0),  m_ovf[0]);
        chk("valid1", int'(v1),  int'(m_n[1] > 0));
        chk("time1",  int'(t1),  m_last[1]);
        chk("level1", int'(l1),  m_n[1]);
        chk("total1", int'(tc1), m_tot[1]);
        chk("drop1",  int'(dc1), m_drop[1]);
        chk("ovf1",   int'(o1),  m_ovf[1]);
    endtask

    // Inputs change at the falling edge; outputs are checked at the next one.
    task automatic step(input logic m, input logic r, input logic c);
        match = m; ready = r; clr = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, r, 1'b0);
    endtask

    int exp_order[4];

    initial begin
        rst = 1'b1; clr = 1'b0; match = 1'b0; ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // Single event at ts=5, visible at ts=6 for one cycle.
        idle(5, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        chk("single_valid", int'(v0), 1);
        chk("single_time", int'(t0), 5);
        step(1'b0, 1'b1, 1'b0);
        chk("single_drained", int'(l0), 0);
        chk("single_total", int'(tc0), 1);

        // Fill and drop.
        step(1'b0, 1'b0, 1'b1);
        idle(2, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
        chk("fill_level", int'(l0), 4);
        chk("fill_drop", int'(dc0), 2);
        chk("fill_ovf", int'(o0), 1);
        chk("fill_total", int'(tc0), 6);
        for (int i = 0; i < 4; i++) begin
            chk("fill_order", int'(t0), 2 + i);
            step(1'b0, 1'b1, 1'b0);
        end
        chk("fill_ovf_sticky", int'(o0), 1);

        // Full FIFO with simultaneous push and pop.
        step(1'b0, 1'b0, 1'b1);
        idle(10, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
        idle(6, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk("pp_level", int'(l0), 4);
        chk("pp_drop", int'(dc0), 0);
        exp_order = '{11, 12, 13, 20};
        for (int i = 0; i < 4; i++) begin
            chk("pp_order", int'(t0), exp_order[i]);
            step(1'b0, 1'b1, 1'b0);
        end

        // Timestamp wrap and counter saturation on the narrow instance.
        step(1'b0, 1'b0, 1'b1);
        idle(15, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("wrap_first", int'(t1), 15);
        step(1'b0, 1'b1, 1'b0);
        chk("wrap_second", int'(t1), 0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
        chk("sat_drop", int'(dc1), 3);
        chk("sat_total", int'(tc1), 3);

        // Clear mid-stream, coincident with match and ready.
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        chk("clr_valid", int'(v0), 0);
        chk("clr_level", int'(l0), 0);
        chk("clr_total", int'(tc0), 0);
        chk("clr_ovf", int'(o0), 0);
        step(1'b1, 1'b0, 1'b0);
        chk("clr_ts_zero", int'(t0), 0);

        // Asynchronous reset between edges with records queued.
        idle(3, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        match = 1'b0; ready = 1'b0;
        #2 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("arst_valid", int'(v0), 0);
        chk("arst_level", int'(l0), 0);
        chk("arst_total", int'(tc0), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        chk("arst_ts_zero", int'(t0), 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < 40),
                 1'($urandom_range(0, 99) < 2));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
